// File: rtl/captura_muestras_if.sv
// rtl/captura_muestras_if.sv - capture request/serial input and frame output bundle
interface captura_muestras_if #(
  parameter int N = 1024
);
  logic         Start;
  logic         In_bit;
  logic         In_valid;
  logic         Frame_ack;
  logic [N-1:0] Frame;
  logic         Frame_valid;
  logic         Busy;
  logic         Overrun;

  modport master (
    output Start, In_bit, In_valid, Frame_ack,
    input  Frame, Frame_valid, Busy, Overrun
  );

  modport slave (
    input  Start, In_bit, In_valid, Frame_ack,
    output Frame, Frame_valid, Busy, Overrun
  );
endinterface

// File: rtl/captura_muestras.sv
// rtl/captura_muestras.sv - oversampled serial frame capture with valid/ack frame handoff
// Continuous capture with overrun detection is built only when CAPTURA_CONTINUO_EN is defined.
module captura_muestras #(
  parameter int SAMPLES = 128,
  parameter int OSF     = 8
) (
  input logic               clk,
  input logic               rst,
  captura_muestras_if.slave bus
);
  localparam int N  = SAMPLES * OSF;
  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    HOLD    = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [CW-1:0] r_cnt;
  // Only N-1 history bits are kept: the oldest bit leaves straight into Frame on completion.
  logic [N-2:0]  r_shift;
  logic [N-1:0]  r_frame;
  logic          r_frame_valid;
  logic [N-1:0]  w_shift_full;
  logic          w_take;
  logic          w_done;
  logic          w_load;
  logic          w_release;
`ifdef CAPTURA_CONTINUO_EN
  logic          r_overrun;
  logic          w_drop;
`endif

  assign w_shift_full = {r_shift, bus.In_bit};

  always_comb begin
    w_state_next = r_state;
    w_take       = (r_state == CAPTURE) && bus.In_valid;
    w_done       = w_take && (r_cnt == LAST);
    w_release    = r_frame_valid && bus.Frame_ack;
`ifdef CAPTURA_CONTINUO_EN
    // A completed frame is only accepted if the output slot is free or being freed this cycle.
    w_load       = w_done && (!r_frame_valid || bus.Frame_ack);
    w_drop       = w_done && !w_load;
`else
    w_load       = w_done;
`endif
    case (r_state)
      IDLE: begin
        if (bus.Start) w_state_next = CAPTURE;
      end
      CAPTURE: begin
`ifndef CAPTURA_CONTINUO_EN
        if (w_done) w_state_next = HOLD;
`endif
      end
      HOLD: begin
        if (bus.Frame_ack) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_shift <= '0;
    end else if (r_state == IDLE && bus.Start) begin
      r_cnt <= '0;
    end else if (w_take) begin
      r_shift <= w_shift_full[N-2:0];
      r_cnt   <= w_done ? '0 : r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frame       <= '0;
      r_frame_valid <= 1'b0;
    end else if (w_load) begin
      r_frame       <= w_shift_full;
      r_frame_valid <= 1'b1;
    end else if (w_release) begin
      r_frame_valid <= 1'b0;
    end
  end

`ifdef CAPTURA_CONTINUO_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_overrun <= 1'b0;
    else if (w_drop) r_overrun <= 1'b1;
  end

  assign bus.Overrun = r_overrun;
`else
  assign bus.Overrun = 1'b0;
`endif

  assign bus.Frame       = r_frame;
  assign bus.Frame_valid = r_frame_valid;
  assign bus.Busy        = (r_state == CAPTURE);
endmodule

// File: tb/tb_captura_muestras.sv
// tb/tb_captura_muestras.sv - scoreboard bench for captura_muestras (8-bit and default 1024-bit frames)
module tb_captura_muestras;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  captura_muestras_if #(.N(8))    bs();
  captura_muestras_if #(.N(1024)) bd();

  captura_muestras #(.SAMPLES(4), .OSF(2)) dut_s (.clk(clk), .rst(rst), .bus(bs.slave));
  captura_muestras                         dut_d (.clk(clk), .rst(rst), .bus(bd.slave));

  int checks   = 0;
  int failures = 0;

  logic [7:0]    exp_s[$];
  logic [1023:0] exp_d[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Small-frame monitor: every newly presented frame is matched against the scoreboard.
  logic [7:0] prev_frame_s = '0;
  logic       prev_valid_s = 1'b0;
  always @(negedge clk) begin
    if (bs.Frame_valid && prev_valid_s) begin
`ifndef CAPTURA_CONTINUO_EN
      check("frame_stable", bs.Frame, prev_frame_s);
`else
      if (bs.Frame !== prev_frame_s) begin
        if (exp_s.size() == 0) begin
          checks++; failures++;
          $display("FAIL sb_unexpected got=%h exp=none", bs.Frame);
        end else check("sb_frame", bs.Frame, exp_s.pop_front());
      end
`endif
    end else if (bs.Frame_valid) begin
      if (exp_s.size() == 0) begin
        checks++; failures++;
        $display("FAIL sb_unexpected got=%h exp=none", bs.Frame);
      end else check("sb_frame", bs.Frame, exp_s.pop_front());
    end
    prev_valid_s = bs.Frame_valid;
    prev_frame_s = bs.Frame;
  end

  logic prev_valid_d = 1'b0;
  always @(negedge clk) begin
    logic [1023:0] e;
    if (bd.Frame_valid && !prev_valid_d) begin
      checks++;
      if (exp_d.size() == 0) begin
        failures++;
        $display("FAIL sb_big_unexpected got_lo=%h exp=none", bd.Frame[63:0]);
      end else begin
        e = exp_d.pop_front();
        if (bd.Frame !== e) begin
          failures++;
          $display("FAIL sb_big_frame got_lo=%h exp_lo=%h got_hi=%h exp_hi=%h",
                   bd.Frame[63:0], e[63:0], bd.Frame[1023:960], e[1023:960]);
        end
      end
    end
    prev_valid_d = bd.Frame_valid;
  end

  task automatic chk_zero(input string tag);
    check({tag, "_frame"},   {56'd0, bs.Frame}, 64'd0);
    check({tag, "_valid"},   bs.Frame_valid, 1'b0);
    check({tag, "_busy"},    bs.Busy, 1'b0);
    check({tag, "_overrun"}, bs.Overrun, 1'b0);
    check({tag, "_big"},     {61'd0, |bd.Frame, bd.Frame_valid, bd.Busy}, 64'd0);
  endtask

  task automatic start_s();
    bs.Start    = 1'b1;
    bs.In_valid = 1'b1;
    bs.In_bit   = 1'($urandom);
    tick();
    bs.Start    = 1'b0;
    bs.In_valid = 1'b0;
  endtask

  // gap_mode: 0 back-to-back, 1 one idle cycle before every bit, 2 random idle cycles
  task automatic send_s(input logic [7:0] pat, input int nbits, input int gap_mode,
                        input bit spur, input bit early_chk, input bit ack_last);
    for (int i = 0; i < nbits; i++) begin
      int gaps;
      gaps = (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
      repeat (gaps) begin
        bs.In_valid = 1'b0;
        bs.In_bit   = 1'($urandom);
        bs.Start    = spur ? 1'($urandom) : 1'b0;
        tick();
      end
      bs.Start     = spur ? 1'($urandom) : 1'b0;
      bs.In_valid  = 1'b1;
      bs.In_bit    = pat[7-i];
      bs.Frame_ack = ack_last && (i == nbits - 1);
      if (early_chk && i == nbits - 1) begin
        @(negedge clk);
        check("no_early_valid", bs.Frame_valid, 1'b0);
      end
      tick();
    end
    bs.In_valid  = 1'b0;
    bs.Start     = 1'b0;
    bs.Frame_ack = 1'b0;
  endtask

  task automatic ack_s();
    bs.Frame_ack = 1'b1;
    bs.Start     = 1'b0;
    bs.In_valid  = 1'b0;
    tick();
    bs.Frame_ack = 1'b0;
    @(negedge clk);
    check("ack_clears_valid", bs.Frame_valid, 1'b0);
`ifndef CAPTURA_CONTINUO_EN
    check("idle_after_ack_busy", bs.Busy, 1'b0);
`endif
  endtask

  initial begin
    logic [7:0]    pat;
    logic [1023:0] big;
    int            n;
    rst = 1'b1;
    bs.Start = 1'b0; bs.In_bit = 1'b0; bs.In_valid = 1'b0; bs.Frame_ack = 1'b0;
    bd.Start = 1'b0; bd.In_bit = 1'b0; bd.In_valid = 1'b0; bd.Frame_ack = 1'b0;
    @(negedge clk);
    chk_zero("reset");
    tick();
    rst = 1'b0;

    // Reset in the middle of a capture discards the partial frame.
    start_s();
    send_s(8'hFF, 5, 0, 0, 0, 0);
    rst = 1'b1;
    @(negedge clk);
    chk_zero("rst_mid");
    tick();
    rst = 1'b0;
    start_s();
    exp_s.push_back(8'hFF);
    send_s(8'hFF, 8, 0, 0, 1, 0);
    @(negedge clk);
    check("ff_valid", bs.Frame_valid, 1'b1);
    check("ff_frame", bs.Frame, 8'hFF);
    ack_s();

`ifndef CAPTURA_CONTINUO_EN
    start_s();
    @(negedge clk);
    check("capture_busy", bs.Busy, 1'b1);
    exp_s.push_back(8'hB2);
    send_s(8'hB2, 8, 0, 0, 1, 0);
    @(negedge clk);
    check("b2_valid", bs.Frame_valid, 1'b1);
    check("b2_frame", bs.Frame, 8'hB2);
    check("hold_busy", bs.Busy, 1'b0);
    check("hold_overrun", bs.Overrun, 1'b0);
    repeat (10) begin
      tick();
      @(negedge clk);
      check("hold_valid", bs.Frame_valid, 1'b1);
      check("hold_frame", bs.Frame, 8'hB2);
    end
    ack_s();

    start_s();
    exp_s.push_back(8'hB2);
    send_s(8'hB2, 8, 1, 0, 1, 0);
    @(negedge clk);
    check("gap_valid", bs.Frame_valid, 1'b1);
    check("gap_frame", bs.Frame, 8'hB2);
    ack_s();

    // Random frames with gaps, ignored Start pulses and junk input outside CAPTURE.
    repeat (20) begin
      repeat ($urandom_range(0, 3)) begin
        bs.In_valid = 1'($urandom);
        bs.In_bit   = 1'($urandom);
        tick();
      end
      bs.In_valid = 1'b0;
      start_s();
      pat = 8'($urandom);
      exp_s.push_back(pat);
      send_s(pat, 8, 2, 1, 1, 0);
      @(negedge clk);
      check("rnd_valid", bs.Frame_valid, 1'b1);
      check("rnd_busy", bs.Busy, 1'b0);
      repeat ($urandom_range(0, 5)) begin
        bs.In_valid = 1'($urandom);
        bs.In_bit   = 1'($urandom);
        bs.Start    = 1'($urandom);
        tick();
      end
      ack_s();
    end

    // Default size: 1024 alternating bits starting with 1; first bit lands at the MSB.
    big = '0;
    for (int i = 0; i < 1024; i++) big[1023-i] = (i % 2 == 0);
    exp_d.push_back(big);
    bd.Start = 1'b1;
    tick();
    bd.Start = 1'b0;
    for (int i = 0; i < 1024; i++) begin
      bd.In_valid = 1'b1;
      bd.In_bit   = (i % 2 == 0);
      tick();
    end
    bd.In_valid = 1'b0;
    @(negedge clk);
    check("big_valid", bd.Frame_valid, 1'b1);
    check("big_busy", bd.Busy, 1'b0);
    check("big_frame_lo", bd.Frame[63:0], 64'hAAAA_AAAA_AAAA_AAAA);
    bd.Frame_ack = 1'b1;
    tick();
    bd.Frame_ack = 1'b0;
    @(negedge clk);
    check("big_ack", bd.Frame_valid, 1'b0);
`else
    rst = 1'b1;
    tick();
    rst = 1'b0;
    start_s();
    exp_s.push_back(8'h5A);
    send_s(8'h5A, 8, 0, 0, 1, 0);
    send_s(8'hC3, 8, 0, 0, 0, 0);
    @(negedge clk);
    check("cont_keep_frame", bs.Frame, 8'h5A);
    check("cont_keep_valid", bs.Frame_valid, 1'b1);
    check("cont_overrun", bs.Overrun, 1'b1);
    check("cont_busy", bs.Busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check("cont_overrun_rst", bs.Overrun, 1'b0);
    tick();
    rst = 1'b0;
    start_s();
    exp_s.push_back(8'h5A);
    send_s(8'h5A, 8, 0, 0, 1, 0);
    exp_s.push_back(8'hC3);
    send_s(8'hC3, 8, 0, 0, 0, 1);
    @(negedge clk);
    check("cont_ack_frame", bs.Frame, 8'hC3);
    check("cont_ack_valid", bs.Frame_valid, 1'b1);
    check("cont_ack_overrun", bs.Overrun, 1'b0);
`endif

    n = 0;
    while ((exp_s.size() != 0 || exp_d.size() != 0) && n < 20) begin
      tick();
      n++;
    end
    check("sb_drain", 64'(exp_s.size() + exp_d.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/captura_muestras.md
CAPTURA_MUESTRAS -- requirements
Module: captura_muestras

Interface
REQ-001 SHALL have parameter SAMPLES, default 128: number of samples per frame.
REQ-002 SHALL have parameter OSF, default 8: oversampling factor; frame width N = SAMPLES*OSF bits.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port Start  input  1  one-cycle request to begin a frame capture.
REQ-006 SHALL have port In_bit  input  1  oversampled serial data bit.
REQ-007 SHALL have port In_valid  input  1  qualifies In_bit in the current cycle.
REQ-008 SHALL have port Frame_ack  input  1  consumer acknowledgment of the presented frame.
REQ-009 SHALL have port Frame  output  N  registered captured frame; feeds the decomposition/summation stage Input bus.
REQ-010 SHALL have port Frame_valid  output  1  Frame holds a complete, unacknowledged frame.
REQ-011 SHALL have port Busy  output  1  high while in CAPTURE.
REQ-012 SHALL have port Overrun  output  1  sticky flag: a completed frame was dropped.

Function
REQ-013 SHALL implement states IDLE, CAPTURE and HOLD, encoded in a registered state variable.
REQ-014 SHALL transition IDLE->CAPTURE on Start=1, clearing the bit counter; an In_valid bit in that same cycle is not captured.
REQ-015 SHALL ignore Start while in CAPTURE or HOLD.
REQ-016 SHALL, in CAPTURE, capture In_bit on each cycle with In_valid=1: shift register <= {shift[N-2:0], In_bit}, and increment a counter of width $clog2(N)+1.
REQ-017 SHALL make the first captured bit land at Frame[N-1] and the last at Frame[0].
REQ-018 SHALL leave shift register and counter unchanged on cycles with In_valid=0 (gaps allowed, no timeout).
REQ-019 SHALL, on the cycle the N-th bit is captured, load Frame from the completed shift contents; Frame_valid SHALL be 1 from the next cycle (latency 1 cycle after the last bit).
REQ-020 SHALL hold Frame stable while Frame_valid=1, except as allowed by REQ-027.
REQ-021 SHALL clear Frame_valid on the cycle after Frame_ack=1 while Frame_valid=1; Frame_ack while Frame_valid=0 SHALL have no effect.
REQ-022 SHALL, without continuous mode, go CAPTURE->HOLD at frame completion and HOLD->IDLE on Frame_ack; In_valid SHALL be ignored in HOLD and IDLE.
REQ-023 SHALL assert Busy exactly when state = CAPTURE.
REQ-024 SHALL be fully synchronous apart from rst; no combinational path from inputs to outputs.

Reset
REQ-025 SHALL, on rst=1 at any time including mid-capture, force state IDLE, counter 0, shift register 0, Frame 0, Frame_valid 0, Busy 0, Overrun 0; any partial frame SHALL be discarded.

Configuration
REQ-026 SHALL compile continuous capture only when macro CAPTURA_CONTINUO_EN is defined; without it, behaviour is exactly REQ-022 and Overrun SHALL be tied 0.
REQ-027 SHALL, with CAPTURA_CONTINUO_EN defined, stay in CAPTURE after a frame completes (counter restarts at 0; HOLD unused); at completion, if Frame_valid=0 or Frame_ack=1 in that cycle, load Frame and keep/assert Frame_valid; otherwise discard the new frame, keep the old Frame and set Overrun=1 until rst.

Verification
REQ-028 SHALL verify (SAMPLES=4, OSF=2, N=8): Start, then bits 1,0,1,1,0,0,1,0 on consecutive In_valid cycles -> Frame=8'hB2, Frame_valid=1 one cycle after the 8th bit, Busy=0 in HOLD.
REQ-029 SHALL verify gapped input: same bits with In_valid=0 on every other cycle -> Frame=8'hB2, with no early Frame_valid.
REQ-030 SHALL verify handshake: Frame_ack held 0 for 10 cycles -> Frame stable, Frame_valid=1; Frame_ack=1 -> Frame_valid=0 next cycle, state IDLE.
REQ-031 SHALL verify reset mid-operation: rst after 5 bits -> all outputs 0; new Start plus 8 bits of 8'hFF -> Frame=8'hFF.
REQ-032 SHALL verify CAPTURA_CONTINUO_EN: frames 8'h5A then 8'hC3 with no ack -> Frame stays 8'h5A and Overrun=1; repeat with Frame_ack coincident with completion -> Frame=8'hC3 and Overrun=0.
REQ-033 SHALL verify defaults (SAMPLES=128, OSF=8): 1024 alternating bits starting with 1 -> Frame = 1024-bit pattern {512{2'b10}}.
